// File: rtl/mc_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : mc_mem_bridge
// Description : Stalls the multicycle core while one access is carried over a
//               request/ready memory bus, with wait-state timeout and a
//               saturating stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_mem_bridge #(
    parameter int                 DATA_W   = 16,
    parameter int                 ADDR_W   = 16,
    parameter int                 TIMEOUT  = 64,
    parameter logic [DATA_W-1:0]  ERR_DATA = DATA_W'(16'hFFFF),
    parameter int                 CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                core_access,
    input  logic                core_memwrite,
    input  logic [ADDR_W-1:0]   core_adr,
    input  logic [DATA_W-1:0]   core_writedata,
    output logic [DATA_W-1:0]   core_readdata,
    output logic                core_stall,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_adr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                timeout_err,
    output logic [CNT_W-1:0]    stall_cnt
);

    localparam int              c_tw   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_tw-1:0] c_tlim = (TIMEOUT > 0) ? c_tw'(TIMEOUT - 1) : '0;

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_req  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              w_stall;
    logic              w_abort;
    logic [c_tw-1:0]   r_tcnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_adr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic [CNT_W-1:0]  r_stall_cnt;

    // Abort fires on the last permitted REQ cycle; a zero TIMEOUT never aborts.
    assign w_abort = (TIMEOUT != 0) && !mem_ready && (r_tcnt == c_tlim);

    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        case (r_state)
            c_idle: begin
                w_stall = core_access;
                if (core_access) w_state_nxt = c_req;
            end
            c_req: begin
                w_stall = 1'b1;
                if (mem_ready || w_abort) w_state_nxt = c_done;
            end
            c_done:  w_state_nxt = c_idle;
            default: w_state_nxt = c_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_idle;
            r_tcnt      <= '0;
            r_we        <= 1'b0;
            r_adr       <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
            case (r_state)
                c_idle: begin
                    if (core_access) begin
                        r_adr   <= core_adr;
                        r_wdata <= core_writedata;
                        r_we    <= core_memwrite;
                        r_tcnt  <= '0;
                    end
                end
                c_req: begin
                    if (mem_ready) begin
                        if (!r_we) r_rdata <= mem_rdata;
                    end else if (w_abort) begin
                        r_err <= 1'b1;
                        if (!r_we) r_rdata <= ERR_DATA;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign core_stall    = w_stall;
    assign mem_req       = (r_state == c_req);
    assign mem_we        = r_we;
    assign mem_adr       = r_adr;
    assign mem_wdata     = r_wdata;
    assign core_readdata = r_rdata;
    assign timeout_err   = r_err;
    assign stall_cnt     = r_stall_cnt;

endmodule
`default_nettype wire
